// File: rtl/cla_pkg.sv
// Package: cla_pkg
// Shared types and elaboration helpers for the pipelined CLA adder.
package cla_pkg;

  typedef enum logic {
    ADD = 1'b0,
    SUB = 1'b1
  } cla_mode_e;

  // Control part of the per-stage record; data slices live in the top.
  typedef struct packed {
    logic valid;
    logic c;
    logic cout;
    logic ovf;
  } cla_flags_t;

  function automatic int nb(input int w, input int blk);
    if (blk < 1) return 1;
    return w / blk;
  endfunction

  function automatic logic cfg_ok(input int w, input int blk);
    if (blk < 1) return 1'b0;
    if (w < blk) return 1'b0;
    return (w % blk) == 0;
  endfunction

endpackage

// File: rtl/cla_block.sv
// Module: cla_block
// Combinational BLK-bit carry-lookahead block with group G/P outputs.
module cla_block #(
  parameter int BLK = 8
) (
  input  logic [BLK-1:0] a,
  input  logic [BLK-1:0] b,
  input  logic           cin,
  output logic [BLK-1:0] s,
  output logic           cout,
  output logic           cmsb,
  output logic           gg,
  output logic           gp
);

  logic [BLK-1:0] g;
  logic [BLK-1:0] p;
  logic [BLK:0]   c;

  assign g = a & b;
  assign p = a ^ b;

  // Every carry is a flat sum of products of g/p/cin, never a ripple chain.
  always_comb begin
    logic term;
    logic grp;
    term = 1'b0;
    grp  = 1'b0;
    c    = '0;
    c[0] = cin;
    for (int i = 1; i <= BLK; i++) begin
      term = cin;
      for (int j = 0; j < i; j++) term &= p[j];
      c[i] = term;
      for (int j = 0; j < i; j++) begin
        term = g[j];
        for (int m = j + 1; m < i; m++) term &= p[m];
        c[i] |= term;
      end
    end
    for (int j = 0; j < BLK; j++) begin
      term = g[j];
      for (int m = j + 1; m < BLK; m++) term &= p[m];
      grp |= term;
    end
    gg = grp;
  end

  assign gp   = &p;
  assign s    = p ^ c[BLK-1:0];
  assign cout = c[BLK];
  assign cmsb = c[BLK-1];

endmodule

// File: rtl/pipelined_cla_adder.sv
// Module: pipelined_cla_adder
// Pipelined carry-lookahead add/sub resolving one BLK-bit block per stage.
module pipelined_cla_adder
  import cla_pkg::*;
#(
  parameter int W   = 32,
  parameter int BLK = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] s,
  output logic         cout,
  output logic         ovf
);

  localparam int NB = nb(W, BLK);

  typedef struct packed {
    cla_flags_t   f;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] sum;
  } stage_t;

  if (!cfg_ok(W, BLK)) begin : g_cfg_err
    $error("pipelined_cla_adder: W=%0d not a multiple of BLK=%0d", W, BLK);
  end

  stage_t            st [NB+1];
  logic              adv;
  cla_mode_e         mode;
  logic [NB-1:0]     bco;
  logic [NB-1:0]     bcm;
  logic [NB-1:0]     bgg;
  logic [NB-1:0]     bgp;
  logic [NB-1:0][BLK-1:0] bs;
  logic              unused_ok;

  assign adv      = !st[NB].f.valid || out_ready;
  assign in_ready = adv;
  assign mode     = sub ? SUB : ADD;

  for (genvar k = 0; k < NB; k++) begin : g_stage
    cla_block #(
      .BLK(BLK)
    ) u_blk (
      .a    (st[k].a[k*BLK +: BLK]),
      .b    (st[k].b[k*BLK +: BLK]),
      .cin  (st[k].f.c),
      .s    (bs[k]),
      .cout (bco[k]),
      .cmsb (bcm[k]),
      .gg   (bgg[k]),
      .gp   (bgp[k])
    );
  end

  // All stages move in lock-step on adv; a stall freezes the whole pipe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k <= NB; k++) st[k] <= '0;
    end else if (adv) begin
      st[0].f.valid <= in_valid;
      if (in_valid) begin
        st[0].a   <= a;
        st[0].b   <= (mode == SUB) ? ~b : b;
        st[0].f.c <= (mode == SUB) ? 1'b1 : cin;
      end
      for (int k = 0; k < NB; k++) begin
        st[k+1]                     <= st[k];
        st[k+1].sum[k*BLK +: BLK]   <= bs[k];
        st[k+1].f.c                 <= bco[k];
        st[k+1].f.cout              <= bco[k];
        st[k+1].f.ovf               <= bcm[k] ^ bco[k];
      end
    end
  end

  assign out_valid = st[NB].f.valid;
  assign s         = st[NB].sum;
  assign cout      = st[NB].f.cout;
  assign ovf       = st[NB].f.ovf;

  // Group G/P is kept for a future second lookahead level.
  assign unused_ok = ^{bgg, bgp, st[NB].a, st[NB].b, st[NB].f.c};

  property p_hold;
    @(posedge clk) disable iff (!rst_n)
      out_valid && !out_ready |=> out_valid && $stable({s, cout, ovf});
  endproperty
  a_hold: assert property (p_hold);

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Testbench: tb_pipelined_cla_adder
// Directed, streaming, reset and parameter-sweep checks against a reference model.
module tb_pipelined_cla_adder;

  localparam int NCFG = 4;

  function automatic int cfg_w(input int g);
    case (g)
      0: return 8;
      1: return 16;
      2: return 32;
      default: return 64;
    endcase
  endfunction

  function automatic int cfg_blk(input int g);
    case (g)
      0: return 8;
      1: return 4;
      2: return 8;
      default: return 16;
    endcase
  endfunction

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] s;
  logic        cout;
  logic        ovf;

  logic [NCFG-1:0][63:0] swa;
  logic [NCFG-1:0][63:0] swb;
  logic [NCFG-1:0][63:0] sws;
  logic [NCFG-1:0]       sw_iv;
  logic [NCFG-1:0]       sw_ir;
  logic [NCFG-1:0]       sw_ci;
  logic [NCFG-1:0]       sw_sub;
  logic [NCFG-1:0]       sw_ov;
  logic [NCFG-1:0]       sw_or;
  logic [NCFG-1:0]       sw_co;
  logic [NCFG-1:0]       sw_of;

  int pass_cnt;
  int chk_cnt;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  pipelined_cla_adder #(
    .W(16),
    .BLK(4)
  ) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .sub      (sub),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .s        (s),
    .cout     (cout),
    .ovf      (ovf)
  );

  for (genvar g = 0; g < NCFG; g++) begin : g_sw
    localparam int GW = cfg_w(g);
    logic [GW-1:0] so;
    pipelined_cla_adder #(
      .W(GW),
      .BLK(cfg_blk(g))
    ) u_sw (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (sw_iv[g]),
      .in_ready (sw_ir[g]),
      .a        (swa[g][GW-1:0]),
      .b        (swb[g][GW-1:0]),
      .cin      (sw_ci[g]),
      .sub      (sw_sub[g]),
      .out_valid(sw_ov[g]),
      .out_ready(sw_or[g]),
      .s        (so),
      .cout     (sw_co[g]),
      .ovf      (sw_of[g])
    );
    assign sws[g] = 64'(so);
  end

  // Reference: plain integer arithmetic, {s[63:0], cout, ovf}.
  function automatic logic [65:0] ref_calc(input int w, input logic [63:0] ia,
                                           input logic [63:0] ib, input logic ci,
                                           input logic sb_mode);
    logic [63:0]        mask;
    logic [63:0]        ma;
    logic [63:0]        mb;
    logic [65:0]        uw;
    logic signed [67:0] sa;
    logic signed [67:0] sb;
    logic signed [67:0] tot;
    logic signed [67:0] lim;
    logic               co;
    logic               of;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    ma = ia & mask;
    mb = ib & mask;
    if (sb_mode) begin
      uw = {2'b0, ma} - {2'b0, mb};
      co = (ma >= mb);
    end else begin
      uw = {2'b0, ma} + {2'b0, mb} + 66'(ci);
      co = uw[w];
    end
    sa = $signed({4'b0, ma});
    if (ma[w-1]) sa = sa - (68'sd1 <<< w);
    sb = $signed({4'b0, mb});
    if (mb[w-1]) sb = sb - (68'sd1 <<< w);
    if (sb_mode) tot = sa - sb;
    else begin
      tot = sa + sb;
      if (ci) tot = tot + 68'sd1;
    end
    lim = 68'sd1 <<< (w - 1);
    of = (tot >= lim) || (tot < -lim);
    return {uw[63:0] & mask, co, of};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    cin = 1'b0;
    sub = 1'b0;
    swa = '0;
    swb = '0;
    sw_iv = '0;
    sw_ci = '0;
    sw_sub = '0;
    sw_or = '1;
    repeat (3) @(posedge clk);
    #1;
    chk_cnt++;
    if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b want 0", out_valid);
    else pass_cnt++;
    chk_cnt++;
    if (s !== 16'h0000) $display("FAIL rst_s: got %h want 0000", s);
    else pass_cnt++;
    chk_cnt++;
    if (cout !== 1'b0) $display("FAIL rst_cout: got %b want 0", cout);
    else pass_cnt++;
    chk_cnt++;
    if (ovf !== 1'b0) $display("FAIL rst_ovf: got %b want 0", ovf);
    else pass_cnt++;
    chk_cnt++;
    if (in_ready !== 1'b1) $display("FAIL rst_in_ready: got %b want 1", in_ready);
    else pass_cnt++;
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_directed();
    logic [15:0] va [6] = '{16'hFFFF, 16'h7FFF, 16'h1234, 16'h8000, 16'h0003, 16'h1234};
    logic [15:0] vb [6] = '{16'h0001, 16'h0001, 16'h4321, 16'h0001, 16'h0005, 16'h1234};
    logic        vc [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic        vs [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [15:0] es [6] = '{16'h0000, 16'h8000, 16'h5556, 16'h7FFF, 16'hFFFE, 16'h0000};
    logic        ec [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic        eo [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 6; i++) begin
      int n;
      a = va[i];
      b = vb[i];
      cin = vc[i];
      sub = vs[i];
      in_valid = 1'b1;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 20) begin
        @(posedge clk);
        #1;
        n++;
      end
      chk_cnt++;
      if (n !== 4) $display("FAIL dir%0d_latency: got %0d want 4", i, n);
      else pass_cnt++;
      chk_cnt++;
      if (s !== es[i]) $display("FAIL dir%0d_s: got %h want %h", i, s, es[i]);
      else pass_cnt++;
      chk_cnt++;
      if (cout !== ec[i]) $display("FAIL dir%0d_cout: got %b want %b", i, cout, ec[i]);
      else pass_cnt++;
      chk_cnt++;
      if (ovf !== eo[i]) $display("FAIL dir%0d_ovf: got %b want %b", i, ovf, eo[i]);
      else pass_cnt++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_back_to_back();
    logic [65:0] q [$];
    logic [65:0] exp;
    logic [65:0] got;
    logic [17:0] prev_r;
    logic        prev_hold;
    int          sent;
    int          cyc;
    int          stall_left;
    sent = 0;
    cyc = 0;
    stall_left = 0;
    prev_hold = 1'b0;
    prev_r = '0;
    while ((sent < 200 || q.size() != 0) && cyc < 3000) begin
      if (stall_left == 0 && $urandom_range(0, 11) == 0) stall_left = 3;
      out_ready = (stall_left == 0);
      if (stall_left > 0) stall_left--;
      in_valid = (sent < 200) && ($urandom_range(0, 7) != 0);
      a = 16'($urandom);
      b = 16'($urandom);
      cin = 1'($urandom);
      sub = 1'($urandom);
      #1;
      chk_cnt++;
      if (in_ready !== !(out_valid && !out_ready))
        $display("FAIL b2b_in_ready: got %b ov=%b or=%b", in_ready, out_valid, out_ready);
      else pass_cnt++;
      if (prev_hold) begin
        chk_cnt++;
        if ({out_valid, s, cout, ovf} !== {1'b1, prev_r})
          $display("FAIL b2b_stall_hold: got %b_%h want 1_%h", out_valid, {s, cout, ovf}, prev_r);
        else pass_cnt++;
      end
      if (out_valid && out_ready) begin
        chk_cnt++;
        if (q.size() == 0) $display("FAIL b2b_extra: got result %h with empty scoreboard", s);
        else begin
          exp = q.pop_front();
          got = {48'b0, s, cout, ovf};
          if (got !== exp) $display("FAIL b2b_result: got %h want %h", got, exp);
          else pass_cnt++;
        end
      end
      if (in_valid && in_ready) begin
        q.push_back(ref_calc(16, 64'(a), 64'(b), cin, sub));
        sent++;
      end
      prev_hold = out_valid && !out_ready;
      prev_r = {s, cout, ovf};
      @(posedge clk);
      #1;
      cyc++;
    end
    chk_cnt++;
    if (sent != 200 || q.size() != 0)
      $display("FAIL b2b_drain: got sent=%0d pending=%0d want 200/0", sent, q.size());
    else pass_cnt++;
    in_valid = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic test_reset_midflight();
    int n;
    int stale;
    out_ready = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      cin = 1'($urandom);
      sub = 1'b0;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk_cnt++;
    if (out_valid !== 1'b1) $display("FAIL mid_pre: got out_valid=%b want 1", out_valid);
    else pass_cnt++;
    #2 rst_n = 1'b0;
    #1;
    chk_cnt++;
    if (out_valid !== 1'b0) $display("FAIL mid_out_valid: got %b want 0", out_valid);
    else pass_cnt++;
    chk_cnt++;
    if (in_ready !== 1'b1) $display("FAIL mid_in_ready: got %b want 1", in_ready);
    else pass_cnt++;
    chk_cnt++;
    if (s !== 16'h0000) $display("FAIL mid_s: got %h want 0000", s);
    else pass_cnt++;
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    stale = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (out_valid) stale++;
    end
    chk_cnt++;
    if (stale != 0) $display("FAIL mid_stale: got %0d results want 0", stale);
    else pass_cnt++;
  endtask

  task automatic test_sweep();
    for (int g = 0; g < NCFG; g++) begin
      logic [65:0] q [$];
      logic [65:0] exp;
      logic [65:0] got;
      logic [63:0] mask;
      int          w;
      int          nbv;
      int          n;
      int          sent;
      int          cyc;
      w = cfg_w(g);
      nbv = w / cfg_blk(g);
      mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
      swa[g] = {$urandom, $urandom} & mask;
      swb[g] = {$urandom, $urandom} & mask;
      sw_ci[g] = 1'($urandom);
      sw_sub[g] = 1'($urandom);
      sw_or[g] = 1'b1;
      sw_iv[g] = 1'b1;
      exp = ref_calc(w, swa[g], swb[g], sw_ci[g], sw_sub[g]);
      @(posedge clk);
      #1;
      sw_iv[g] = 1'b0;
      n = 0;
      while (!sw_ov[g] && n < 100) begin
        @(posedge clk);
        #1;
        n++;
      end
      chk_cnt++;
      if (n != nbv) $display("FAIL sw%0d_latency: got %0d want %0d", w, n, nbv);
      else pass_cnt++;
      chk_cnt++;
      got = {sws[g], sw_co[g], sw_of[g]};
      if (got !== exp) $display("FAIL sw%0d_single: got %h want %h", w, got, exp);
      else pass_cnt++;
      @(posedge clk);
      #1;
      sent = 0;
      cyc = 0;
      while ((sent < 60 || q.size() != 0) && cyc < 2000) begin
        sw_or[g] = ($urandom_range(0, 3) != 0);
        sw_iv[g] = (sent < 60) && ($urandom_range(0, 3) != 0);
        swa[g] = {$urandom, $urandom} & mask;
        swb[g] = {$urandom, $urandom} & mask;
        if ($urandom_range(0, 7) == 0) swb[g] = mask - swa[g];
        sw_ci[g] = 1'($urandom);
        sw_sub[g] = 1'($urandom);
        #1;
        if (sw_ov[g] && sw_or[g]) begin
          chk_cnt++;
          if (q.size() == 0) $display("FAIL sw%0d_extra: got %h with empty scoreboard", w, sws[g]);
          else begin
            exp = q.pop_front();
            got = {sws[g], sw_co[g], sw_of[g]};
            if (got !== exp) $display("FAIL sw%0d_result: got %h want %h", w, got, exp);
            else pass_cnt++;
          end
        end
        if (sw_iv[g] && sw_ir[g]) begin
          q.push_back(ref_calc(w, swa[g], swb[g], sw_ci[g], sw_sub[g]));
          sent++;
        end
        @(posedge clk);
        #1;
        cyc++;
      end
      chk_cnt++;
      if (sent != 60 || q.size() != 0)
        $display("FAIL sw%0d_drain: got sent=%0d pending=%0d want 60/0", w, sent, q.size());
      else pass_cnt++;
      sw_iv[g] = 1'b0;
      sw_or[g] = 1'b1;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    pass_cnt = 0;
    chk_cnt = 0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_midflight();
    test_sweep();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
